cpu_sequencer: RTL

Multi-cycle control sequencer for the MIPS-style CPU datapath. It replaces single-cycle implicit timing with an explicit FETCH/DECODE/EXEC/MEM/WB state machine. It gates the PC, instruction register, ALU result latch, register-file write and data-memory strobes, and handshakes with instruction and data memories that may insert wait states. It sits between the instruction decoder, which supplies the instruction class, and the datapath enables.

---
 rtl/cpu_seq_pkg.sv | 35 +++
 rtl/seq_wait_timer.sv | 42 ++++
 rtl/cpu_sequencer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_seq_pkg.sv
// ---------------------------------------------------------------------------
// cpu_seq_pkg
// Shared definitions for the multi-cycle CPU control sequencer:
//   - state_t      : sequencer state encoding (also driven on the 3-bit
//                    'state' port of cpu_sequencer)
//   - CLS_*        : bit positions of the instruction-class vector
//   - MEM_WAIT_MAX_DEFAULT : default memory wait limit before ERROR
//   - is_one_hot() : class-vector legality check used in DECODE
// ---------------------------------------------------------------------------
package cpu_seq_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

    localparam int CLS_ALU    = 0;
    localparam int CLS_LOAD   = 1;
    localparam int CLS_STORE  = 2;
    localparam int CLS_BRANCH = 3;
    localparam int CLS_JUMP   = 4;
    localparam int CLS_W      = 5;

    localparam int MEM_WAIT_MAX_DEFAULT = 8;

    function automatic logic is_one_hot(input logic [CLS_W-1:0] v);
        return ($countones(v) == 1);
    endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// ---------------------------------------------------------------------------
// seq_wait_timer
// Saturating count of cycles spent in the current sequencer state. The
// sequencer pulses 'clear' on every state change so each memory access
// starts counting from zero.
//
// Ports:
//   clk     : system clock
//   reset   : synchronous active-high reset
//   clear   : restart the count on the next edge (state is changing)
//   timeout : current cycle is the MAX-th cycle of the state
//
// Parameter MAX: number of cycles allowed in a waiting state.
// ---------------------------------------------------------------------------
module seq_wait_timer #(
    parameter int MAX = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic timeout
);

    localparam int W = (MAX < 2) ? 1 : $clog2(MAX + 1);
    localparam logic [W-1:0] LAST = W'(MAX - 1);

    logic [W-1:0] count;

    // The count holds the number of cycles already spent in the state, so
    // reaching LAST means the current cycle is the MAX-th one. It sticks
    // there so timeout stays asserted in long-lived states.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (count != LAST) begin
            count <= count + W'(1);
        end
    end

    assign timeout = (count == LAST);

endmodule

// File: rtl/cpu_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_sequencer
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the MIPS-style
// datapath. Generates the datapath enables and memory handshakes. Memories
// may insert wait states; a wait longer than MEM_WAIT_MAX cycles, or an
// illegal instruction class, parks the sequencer in ERROR until reset.
//
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   imem_ack, dmem_ack      : memory completion handshakes
//   cls_alu..cls_jump       : one-hot instruction class, sampled in DECODE
//   halt_req                : debug halt, honoured only at retire / in HALT
//   imem_req, ir_en         : fetch request, instruction register load
//   alu_en                  : ALU result/zero latch
//   dmem_req, dmem_wr       : data memory request and write qualifier
//   reg_we, pc_en           : register-file write, PC update
//   state                   : current state encoding (cpu_seq_pkg::state_t)
//   halted, error           : registered status flags
//   cycle_cnt, instr_cnt    : performance counters
//
// Build option: define SEQ_PERF_CNT_EN to implement the performance
// counters; otherwise both counters read as zero and have no flops.
// ---------------------------------------------------------------------------
module cpu_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int MEM_WAIT_MAX = MEM_WAIT_MAX_DEFAULT,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    input  logic             cls_alu,
    input  logic             cls_load,
    input  logic             cls_store,
    input  logic             cls_branch,
    input  logic             cls_jump,
    input  logic             halt_req,
    output logic             imem_req,
    output logic             ir_en,
    output logic             alu_en,
    output logic             dmem_req,
    output logic             dmem_wr,
    output logic             reg_we,
    output logic             pc_en,
    output logic [2:0]       state,
    output logic             halted,
    output logic             error,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    state_t             state_q;
    state_t             state_next;
    logic [CLS_W-1:0]   cls_in;
    logic [CLS_W-1:0]   cls_q;
    logic               halted_q;
    logic               error_q;
    logic               retire;
    logic               wait_clear;
    logic               wait_timeout;

    always_comb begin
        cls_in             = '0;
        cls_in[CLS_ALU]    = cls_alu;
        cls_in[CLS_LOAD]   = cls_load;
        cls_in[CLS_STORE]  = cls_store;
        cls_in[CLS_BRANCH] = cls_branch;
        cls_in[CLS_JUMP]   = cls_jump;
    end

    // Restart the wait count whenever the state is about to change.
    assign wait_clear = (state_next != state_q);

    seq_wait_timer #(
        .MAX (MEM_WAIT_MAX)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (wait_clear),
        .timeout (wait_timeout)
    );

    // Next-state and strobe decode. An ack arriving in the timeout cycle is
    // checked first, so it completes the access rather than faulting.
    always_comb begin
        state_next = state_q;
        retire     = 1'b0;
        imem_req   = 1'b0;
        ir_en      = 1'b0;
        alu_en     = 1'b0;
        dmem_req   = 1'b0;
        dmem_wr    = 1'b0;
        reg_we     = 1'b0;
        pc_en      = 1'b0;

        case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_en      = 1'b1;
                    state_next = ST_DECODE;
                end else if (wait_timeout) begin
                    state_next = ST_ERROR;
                end
            end
            ST_DECODE: begin
                state_next = is_one_hot(cls_in) ? ST_EXEC : ST_ERROR;
            end
            ST_EXEC: begin
                alu_en = 1'b1;
                if (cls_q[CLS_BRANCH] || cls_q[CLS_JUMP]) begin
                    pc_en  = 1'b1;
                    retire = 1'b1;
                end else if (cls_q[CLS_LOAD] || cls_q[CLS_STORE]) begin
                    state_next = ST_MEM;
                end else if (cls_q[CLS_ALU]) begin
                    state_next = ST_WB;
                end else begin
                    state_next = ST_ERROR;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_wr  = cls_q[CLS_STORE];
                if (dmem_ack) begin
                    if (cls_q[CLS_STORE]) begin
                        pc_en  = 1'b1;
                        retire = 1'b1;
                    end else begin
                        state_next = ST_WB;
                    end
                end else if (wait_timeout) begin
                    state_next = ST_ERROR;
                end
            end
            ST_WB: begin
                reg_we = 1'b1;
                pc_en  = 1'b1;
                retire = 1'b1;
            end
            ST_HALT: begin
                if (!halt_req) begin
                    state_next = ST_FETCH;
                end
            end
            ST_ERROR: begin
                state_next = ST_ERROR;
            end
            default: begin
                state_next = ST_ERROR;
            end
        endcase

        if (retire) begin
            state_next = halt_req ? ST_HALT : ST_FETCH;
        end

        // Reset aborts the instruction in flight: nothing it would commit
        // this cycle may reach the datapath.
        if (reset) begin
            ir_en    = 1'b0;
            alu_en   = 1'b0;
            dmem_req = 1'b0;
            dmem_wr  = 1'b0;
            reg_we   = 1'b0;
            pc_en    = 1'b0;
        end
    end

    // State register; halted/error are registered from the next state so
    // they line up exactly with being in HALT/ERROR.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_FETCH;
            cls_q    <= '0;
            halted_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_next;
            if (state_q == ST_DECODE) begin
                cls_q <= cls_in;
            end
            halted_q <= (state_next == ST_HALT);
            error_q  <= (state_next == ST_ERROR);
        end
    end

    assign state  = state_q;
    assign halted = halted_q;
    assign error  = error_q;

`ifdef SEQ_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_q;
    logic [CNT_W-1:0] instr_cnt_q;

    // Free-running counters; they wrap naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
            if (retire) begin
                instr_cnt_q <= instr_cnt_q + CNT_W'(1);
            end
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`else
    assign cycle_cnt = '0;
    assign instr_cnt = '0;
`endif

endmodule
